// File: rtl/count_pkg.sv
// Shared types and helpers for the multi-digit BCD counter.
package count_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;  // all segments off (active-low)
  localparam logic [3:0] BCD_MAX   = 4'd9;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic carry;
    bcd_t digit;
  } bcd_step_t;

  // One BCD digit of an up/down ripple chain. en is the carry/borrow from
  // the digit below (or the tick for digit 0); carry goes to the digit above.
  function automatic bcd_step_t bcd_step(input bcd_t d, input logic up, input logic en);
    bcd_step_t r;
    r.carry = 1'b0;
    r.digit = d;
    if (en) begin
      if (up) begin
        if (d >= BCD_MAX) begin
          r.digit = '0;
          r.carry = 1'b1;
        end else begin
          r.digit = d + 4'd1;
        end
      end else begin
        if (d == '0) begin
          r.digit = BCD_MAX;
          r.carry = 1'b1;
        end else begin
          r.digit = d - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/count_bcd_ndigit_decord_7seg.sv
// BCD digit to active-low 7-segment pattern (bit 7 = decimal point, off).
module decord_7seg
  import count_pkg::*;
(
  input  logic [3:0] SW,
  output logic [7:0] HEX
);

  // Combinational segment lookup; non-BCD codes show nothing.
  always_comb begin
    case (SW)
      4'd0:    HEX = 8'hC0;
      4'd1:    HEX = 8'hF9;
      4'd2:    HEX = 8'hA4;
      4'd3:    HEX = 8'hB0;
      4'd4:    HEX = 8'h99;
      4'd5:    HEX = 8'h92;
      4'd6:    HEX = 8'h82;
      4'd7:    HEX = 8'hF8;
      4'd8:    HEX = 8'h80;
      4'd9:    HEX = 8'h90;
      default: HEX = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_bcd_ndigit.sv
// Multi-digit BCD up/down counter with tick prescaler, start/stop/clear
// control, wrap pulse and per-digit 7-segment outputs.
// Optional build macro: COUNT_BCD_LZ_BLANK_EN (leading-zero blanking on HEX).
//
// state | meaning
// IDLE  | count frozen, prescaler held at 0
// RUN   | prescaler running, count steps once per tick
module count_bcd_ndigit
  import count_pkg::*;
#(
  parameter int FREQ    = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  up_dn,
  output logic                  running,
  output logic                  wrap,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [8*DIGITS-1:0]   HEX
);

  localparam int DIV = FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

  state_t                state_q, state_d;
  logic [PW-1:0]         presc_q;
  logic                  tick;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [DIGITS:0]       chain;
  bcd_step_t             step;
  logic [8*DIGITS-1:0]   seg_raw;

  assign tick    = (state_q == RUN) && (presc_q == DIV_M1);
  assign running = (state_q == RUN);
  assign bcd     = bcd_q;

  // Next state: a lone start or lone stop moves the FSM; both together do nothing.
  always_comb begin
    state_d = state_q;
    if (start && !stop)
      state_d = RUN;
    else if (stop && !start)
      state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Prescaler: counts only in RUN, zeroed on tick, clear, or when leaving RUN.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      presc_q <= '0;
    else if (clear || (state_q != RUN) || (state_d == IDLE) || tick)
      presc_q <= '0;
    else
      presc_q <= presc_q + 1'b1;
  end

  // Ripple the tick through all digits in one cycle; chain top is the wrap.
  always_comb begin
    chain    = '0;
    chain[0] = tick;
    bcd_d    = bcd_q;
    step     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      step              = bcd_step(bcd_q[4*i +: 4], up_dn, chain[i]);
      bcd_d[4*i +: 4]   = step.digit;
      chain[i+1]        = step.carry;
    end
  end

  // Count and wrap registers; clear overrides a coincident tick.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bcd_q <= '0;
      wrap  <= 1'b0;
    end else if (clear) begin
      bcd_q <= '0;
      wrap  <= 1'b0;
    end else begin
      bcd_q <= bcd_d;
      wrap  <= chain[DIGITS];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    decord_7seg u_dec (
      .SW  (bcd_q[4*g +: 4]),
      .HEX (seg_raw[8*g +: 8])
    );
  end

`ifdef COUNT_BCD_LZ_BLANK_EN
  logic [DIGITS-1:0] lz;  // this digit and every digit above it are zero

  // Blank leading zeros above digit 0; digit 0 is always shown.
  always_comb begin
    lz  = '0;
    HEX = seg_raw;
    lz[DIGITS-1] = (bcd_q[4*(DIGITS-1) +: 4] == '0);
    for (int i = DIGITS - 2; i >= 0; i--)
      lz[i] = lz[i+1] && (bcd_q[4*i +: 4] == '0);
    for (int i = 1; i < DIGITS; i++)
      if (lz[i])
        HEX[8*i +: 8] = SEG_BLANK;
  end
`else
  assign HEX = seg_raw;
`endif

endmodule

// File: tb/tb_count_bcd_ndigit.sv
// Scoreboard bench for count_bcd_ndigit with FREQ=10, TICK_HZ=1, DIGITS=2.
module tb_count_bcd_ndigit;
  import count_pkg::*;

  localparam int FREQ    = 10;
  localparam int TICK_HZ = 1;
  localparam int DIGITS  = 2;
  localparam int DIV     = FREQ / TICK_HZ;
  localparam int NVAL    = 100;   // 10**DIGITS

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start, stop, clear, up_dn;
  logic         running, wrap;
  logic [7:0]   bcd;
  logic [15:0]  HEX;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        running;
    logic        wrap;
    logic [7:0]  bcd;
    logic [15:0] hex;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Reference model state: count kept as a plain integer.
  logic m_run;
  int   m_cnt;
  int   m_presc;
  logic m_wrap;

  count_bcd_ndigit #(.FREQ(FREQ), .TICK_HZ(TICK_HZ), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .up_dn   (up_dn),
    .running (running),
    .wrap    (wrap),
    .bcd     (bcd),
    .HEX     (HEX)
  );

  always #5 clk = ~clk;

  function automatic exp_t exp_of(input logic r, input int cnt, input logic w);
    exp_t e;
    int   d0, d1;
    d0 = cnt % 10;
    d1 = (cnt / 10) % 10;
    e.running = r;
    e.wrap    = w;
    e.bcd     = {4'(d1), 4'(d0)};
    e.hex     = {seg_tab[d1], seg_tab[d0]};
`ifdef COUNT_BCD_LZ_BLANK_EN
    if (cnt < 10) e.hex[15:8] = SEG_BLANK;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, advance the model, queue the expected outputs.
  task automatic cyc(input logic s, input logic p, input logic c, input logic u);
    logic tk;
    start = s; stop = p; clear = c; up_dn = u;
    tk = m_run && (m_presc == DIV - 1);
    if (c) begin
      m_cnt = 0; m_wrap = 1'b0;
    end else if (tk) begin
      if (u) begin
        m_wrap = (m_cnt == NVAL - 1);
        m_cnt  = (m_cnt + 1) % NVAL;
      end else begin
        m_wrap = (m_cnt == 0);
        m_cnt  = (m_cnt + NVAL - 1) % NVAL;
      end
    end else begin
      m_wrap = 1'b0;
    end
    if (c || !m_run || (p && !s) || tk) m_presc = 0;
    else                                m_presc = m_presc + 1;
    if (s && !p)      m_run = 1'b1;
    else if (p && !s) m_run = 1'b0;
    exp_q.push_back(exp_of(m_run, m_cnt, m_wrap));
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_cnt = 0; m_presc = 0; m_wrap = 1'b0;
  endtask

  // Monitor: each edge presents an output; pop the matching expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("running", 16'(running), 16'(e.running));
        chk("wrap",    16'(wrap),    16'(e.wrap));
        chk("bcd",     16'(bcd),     16'(e.bcd));
        chk("hex",     HEX,          e.hex);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    exp_t r;
    start = 0; stop = 0; clear = 0; up_dn = 1;
    n_rst = 1'b0;
    model_reset();
    #13;
    r = exp_of(1'b0, 0, 1'b0);
    chk("rst_running", 16'(running), 16'(r.running));
    chk("rst_bcd",     16'(bcd),     16'(r.bcd));
    chk("rst_hex",     HEX,          r.hex);
    #10 n_rst = 1'b1;
    @(posedge clk); #2;

    // idle, start+stop together, stop while idle
    repeat (3) cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 1);
    repeat (5) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    repeat (3) cyc(0, 0, 0, 1);

    // count up through the full range and wrap
    cyc(1, 0, 0, 1);
    repeat (1005) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);            // start while running: no restart
    repeat (8) cyc(0, 0, 0, 1);

    // down from 00: borrow wrap then 98
    cyc(0, 0, 1, 0);
    repeat (25) cyc(0, 0, 0, 0);

    // stop at 05, hold, restart
    cyc(0, 0, 1, 1);
    for (int k = 0; k < 200 && m_cnt != 5; k++) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    repeat (50) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    repeat (12) cyc(0, 0, 0, 1);

    // clear coinciding with a tick at 42
    cyc(0, 0, 1, 1);
    for (int k = 0; k < 600 && !(m_cnt == 42 && m_presc == DIV - 1); k++) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    repeat (15) cyc(0, 0, 0, 1);
    repeat (30) cyc(0, 0, 1, 1);  // held clear in RUN

    // randomized control traffic
    for (int k = 0; k < 3000; k++) begin
      logic s, p, c, u;
      s = ($urandom_range(0, 39) == 0);
      p = ($urandom_range(0, 59) == 0);
      c = ($urandom_range(0, 79) == 0);
      u = ($urandom_range(0, 3) != 0);
      cyc(s, p, c, u);
    end

    // async reset mid-count
    cyc(1, 0, 0, 1);
    repeat (37) cyc(0, 0, 0, 1);
    #3 n_rst = 1'b0;
    #1;
    r = exp_of(1'b0, 0, 1'b0);
    chk("async_running", 16'(running), 16'(r.running));
    chk("async_bcd",     16'(bcd),     16'(r.bcd));
    chk("async_wrap",    16'(wrap),    16'(r.wrap));
    chk("async_hex",     HEX,          r.hex);
    #2 n_rst = 1'b1;
    model_reset();
    @(posedge clk); #2;
    cyc(1, 0, 0, 1);
    repeat (25) cyc(0, 0, 0, 1);

    @(posedge clk); #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
